// File: rtl/cache_pkg.sv
// Shared state encoding, default geometry and offset-width helper for the cache refill engine.
package cache_pkg;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, DONE} refill_state_t;

   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_BLK_WORDS  = 8;
   localparam int DEF_WORD_BYTES = 2;

   // Width of an index selecting one of n items; a single item needs no bits.
   function automatic int offset_w(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

endpackage

// File: rtl/refill_counter.sv
// Up-counter with synchronous clear and enable, used for request and response tracking.
module refill_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/cache_refill_engine.sv
// Cache line refill engine: optional dirty-victim writeback, then block fill from memory.
// Writeback path is compiled in only when CACHE_REFILL_WRITEBACK_EN is defined.
module cache_refill_engine
   import cache_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int BLK_WORDS  = DEF_BLK_WORDS,
   parameter int WORD_BYTES = DEF_WORD_BYTES
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          miss_detected,
   input  logic [ADDR_W-1:0]             miss_address,
   input  logic                          victim_dirty,
   input  logic [ADDR_W-1:0]             victim_address,
   input  logic                          mem_ready,
   input  logic                          mem_data_valid,
   output logic                          fsm_busy,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             memory_address,
   output logic [$clog2(BLK_WORDS)-1:0]  word_sel,
   output logic                          write_data_array,
   output logic                          write_tag_array,
   output logic                          fill_done
);

   localparam int IDX_W = offset_w(BLK_WORDS);
   localparam int OFF_W = offset_w(WORD_BYTES);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0]  BLK_CNT  = CNT_W'(BLK_WORDS);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLK_WORDS - 1);
   localparam logic [ADDR_W-1:0] BLK_MASK = ~(ADDR_W'(BLK_WORDS * WORD_BYTES) - ADDR_W'(1));

   refill_state_t     state_q, state_d;
   logic [ADDR_W-1:0] miss_base_q;
   logic [CNT_W-1:0]  req_cnt, rsp_cnt;
   logic              req_clr, rsp_clr, req_en, rsp_en;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
      return base | (ADDR_W'(idx) << OFF_W);
   endfunction

`ifdef CACHE_REFILL_WRITEBACK_EN
   logic [ADDR_W-1:0] victim_base_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         victim_base_q <= '0;
      end else if (state_q == IDLE && miss_detected) begin
         victim_base_q <= victim_address & BLK_MASK;
      end
   end
`else
   logic unused_victim;
   assign unused_victim = ^{victim_dirty, victim_address};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         miss_base_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && miss_detected) begin
            miss_base_q <= miss_address & BLK_MASK;
         end
      end
   end

   refill_counter #(.W(CNT_W)) u_req_cnt (
      .clk (clk),
      .rst (rst),
      .clr (req_clr),
      .en  (req_en),
      .cnt (req_cnt)
   );

   refill_counter #(.W(CNT_W)) u_rsp_cnt (
      .clk (clk),
      .rst (rst),
      .clr (rsp_clr),
      .en  (rsp_en),
      .cnt (rsp_cnt)
   );

   assign fsm_busy = (state_q != IDLE) | miss_detected;

   always_comb begin
      state_d          = state_q;
      mem_req          = 1'b0;
      mem_we           = 1'b0;
      memory_address   = '0;
      word_sel         = '0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
      fill_done        = 1'b0;
      req_clr          = 1'b0;
      rsp_clr          = 1'b0;
      req_en           = 1'b0;
      rsp_en           = 1'b0;

      case (state_q)
         IDLE: begin
            if (miss_detected) begin
               req_clr = 1'b1;
               rsp_clr = 1'b1;
`ifdef CACHE_REFILL_WRITEBACK_EN
               state_d = victim_dirty ? WRITEBACK : FILL;
`else
               state_d = FILL;
`endif
            end
         end
`ifdef CACHE_REFILL_WRITEBACK_EN
         WRITEBACK: begin
            word_sel = req_cnt[IDX_W-1:0];
            if (req_cnt < BLK_CNT) begin
               mem_req        = 1'b1;
               mem_we         = 1'b1;
               memory_address = word_addr(victim_base_q, req_cnt[IDX_W-1:0]);
               req_en         = mem_ready;
               // Last write accepted: restart both counters for the fill phase.
               if (mem_ready && req_cnt == LAST_CNT) begin
                  req_clr = 1'b1;
                  rsp_clr = 1'b1;
                  state_d = FILL;
               end
            end
         end
`endif
         FILL: begin
            word_sel = rsp_cnt[IDX_W-1:0];
            if (req_cnt < BLK_CNT) begin
               mem_req        = 1'b1;
               memory_address = word_addr(miss_base_q, req_cnt[IDX_W-1:0]);
               req_en         = mem_ready;
            end
            if (mem_data_valid && rsp_cnt < BLK_CNT) begin
               write_data_array = 1'b1;
               rsp_en           = 1'b1;
            end
            if (rsp_cnt == BLK_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
